// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: register file geometry and common
// operand types, reused by decode, the ALU and the register file.
package legv8_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int XZR_IDX  = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] dword_t;

    // True when the address selects the hard-wired zero register.
    function automatic logic is_xzr(input reg_addr_t addr);
        return (addr == reg_addr_t'(XZR_IDX));
    endfunction

endpackage

// File: rtl/reg64_cell.sv
// One architectural register: a DATA_W-bit flop with asynchronous
// active-low clear and a write enable. Holds its value when not enabled.
module reg64_cell
    import legv8_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   we,
    input  dword_t d,
    output dword_t q
);

    dword_t q_d;
    dword_t q_q;

    // Next-state: load new data only when this cell is the write target.
    always_comb begin
        q_d = q_q;
        if (we) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // State register; reset clears the cell without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {DATA_W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sixty_four_bit_register_file.sv
// LEGv8 integer register file: 32 x 64-bit, two combinational read ports,
// one synchronous write port. Register 31 (XZR) reads zero and ignores writes.
// Reads are not forwarded from a same-cycle write; the pipeline handles hazards.
module sixty_four_bit_register_file
    import legv8_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t read_reg_address_1,
    input  reg_addr_t read_reg_address_2,
    input  dword_t    data,
    input  reg_addr_t write_reg_address,
    input  logic      reg_write,
    output dword_t    reg_out_1,
    output dword_t    reg_out_2
);

    // Only the 31 real registers get an enable; XZR has no storage.
    logic [NUM_REGS-2:0] we_s;
    dword_t              regs_s [NUM_REGS];
    dword_t              rd1_s;
    dword_t              rd2_s;

    // Write decoder: one-hot of the write address, gated by reg_write.
    always_comb begin
        we_s = {(NUM_REGS-1){1'b0}};
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (reg_write && (write_reg_address == reg_addr_t'(i))) begin
                we_s[i] = 1'b1;
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS - 1; g++) begin : g_cell
            reg64_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (we_s[g]),
                .d     (data),
                .q     (regs_s[g])
            );
        end
    endgenerate

    // XZR is a constant tie-off rather than a flop.
    assign regs_s[XZR_IDX] = {DATA_W{1'b0}};

    // Read port 1 multiplexer; XZR is forced to zero explicitly.
    always_comb begin
        rd1_s = {DATA_W{1'b0}};
        if (is_xzr(read_reg_address_1)) begin
            rd1_s = {DATA_W{1'b0}};
        end else begin
            rd1_s = regs_s[read_reg_address_1];
        end
    end

    // Read port 2 multiplexer, independent of port 1.
    always_comb begin
        rd2_s = {DATA_W{1'b0}};
        if (is_xzr(read_reg_address_2)) begin
            rd2_s = {DATA_W{1'b0}};
        end else begin
            rd2_s = regs_s[read_reg_address_2];
        end
    end

    assign reg_out_1 = rd1_s;
    assign reg_out_2 = rd2_s;

endmodule

// File: tb/tb_sixty_four_bit_register_file.sv
// Self-checking bench for the LEGv8 register file: directed scenarios with
// literal expectations plus randomized traffic against an array model.
module tb_sixty_four_bit_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg_address_1;
    logic [4:0]  read_reg_address_2;
    logic [63:0] data;
    logic [4:0]  write_reg_address;
    logic        reg_write;
    logic [63:0] reg_out_1;
    logic [63:0] reg_out_2;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    // Behavioural model: plain array of register contents.
    logic [63:0] model [32];

    sixty_four_bit_register_file dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .read_reg_address_1 (read_reg_address_1),
        .read_reg_address_2 (read_reg_address_2),
        .data               (data),
        .write_reg_address  (write_reg_address),
        .reg_write          (reg_write),
        .reg_out_1          (reg_out_1),
        .reg_out_2          (reg_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        return model[a];
    endfunction

    // Model update: reset empties the file, an enabled write stores data unless XZR.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (reg_write && write_reg_address != 5'd31) begin
            model[write_reg_address] = data;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison of both read ports against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            check("model_port1", reg_out_1, model_read(read_reg_address_1));
            check("model_port2", reg_out_2, model_read(read_reg_address_2));
        end
    end

    task automatic write_one(input logic [4:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        write_reg_address = a;
        data              = d;
        reg_write         = 1'b1;
        @(posedge clk); #1;
        reg_write         = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        rst_n = 1'b1;
        read_reg_address_1 = 5'd4;
        read_reg_address_2 = 5'd4;
        data = 64'd0;
        write_reg_address = 5'd0;
        reg_write = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_en = 1'b1;

        // 1. Reset: outputs zero during and after reset.
        #10;
        check("reset_during_p1", reg_out_1, 64'd0);
        check("reset_during_p2", reg_out_2, 64'd0);
        #6 rst_n = 1'b1;
        #1;
        check("reset_after_p1", reg_out_1, 64'd0);
        check("reset_after_p2", reg_out_2, 64'd0);

        // 2. Write 43 to reg 9 while reading reg 4, then read reg 9.
        @(posedge clk); #1;
        data = 64'd43; write_reg_address = 5'd9; reg_write = 1'b1;
        #1 check("wr9_pre_edge_p1", reg_out_1, 64'd0);
        @(posedge clk); #1;
        reg_write = 1'b0;
        check("wr9_addr4_p1", reg_out_1, 64'd0);
        read_reg_address_1 = 5'd9;
        #1;
        check("rd9_same_cycle", reg_out_1, 64'd43);
        check("rd4_still_zero", reg_out_2, 64'd0);

        // 3. Write 3 to reg 16, dual read 9 and 16.
        write_one(5'd16, 64'd3);
        read_reg_address_1 = 5'd9;
        read_reg_address_2 = 5'd16;
        #1;
        check("dual_rd9", reg_out_1, 64'd43);
        check("dual_rd16", reg_out_2, 64'd3);

        // 4. XZR: write is discarded, both ports read zero.
        write_one(5'd31, 64'hDEAD_BEEF_0000_0001);
        read_reg_address_1 = 5'd31;
        read_reg_address_2 = 5'd31;
        #1;
        check("xzr_p1", reg_out_1, 64'd0);
        check("xzr_p2", reg_out_2, 64'd0);
        read_reg_address_1 = 5'd9;
        #1 check("rd9_undisturbed", reg_out_1, 64'd43);

        // 5. Read-during-write: old value before the edge, new after.
        write_one(5'd5, 64'd7);
        read_reg_address_1 = 5'd5;
        read_reg_address_2 = 5'd5;
        data = 64'd99; write_reg_address = 5'd5; reg_write = 1'b1;
        #1 check("rdw_before_edge", reg_out_1, 64'd7);
        @(negedge clk); #1;
        check("rdw_late_cycle", reg_out_1, 64'd7);
        @(posedge clk); #1;
        check("rdw_after_edge", reg_out_1, 64'd99);
        check("rdw_both_ports", reg_out_2, 64'd99);
        reg_write = 1'b0;
        data = 64'd123;
        @(posedge clk); #1;
        check("no_write_when_disabled", reg_out_1, 64'd99);

        // 6. Fill 0..30 with index+1, then async reset mid-cycle.
        for (int i = 0; i < 31; i++) begin
            @(posedge clk); #1;
            write_reg_address = 5'(i);
            data = 64'(i + 1);
            reg_write = 1'b1;
        end
        @(posedge clk); #1;
        reg_write = 1'b0;
        read_reg_address_1 = 5'd0;
        read_reg_address_2 = 5'd30;
        #1;
        check("fill_r0", reg_out_1, 64'd1);
        check("fill_r30", reg_out_2, 64'd31);
        read_reg_address_1 = 5'd7;
        data = 64'd555; write_reg_address = 5'd7; reg_write = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_p1", reg_out_1, 64'd0);
        check("async_rst_p2", reg_out_2, 64'd0);
        @(posedge clk); #2;
        reg_write = 1'b0;
        #1 rst_n = 1'b1;
        #1 check("write_during_rst_dropped", reg_out_1, 64'd0);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            read_reg_address_1 = 5'($urandom_range(0, 31));
            read_reg_address_2 = ($urandom_range(0, 7) == 0) ? read_reg_address_1
                                                              : 5'($urandom_range(0, 31));
            write_reg_address  = 5'($urandom_range(0, 31));
            data               = {$urandom, $urandom};
            reg_write          = ($urandom_range(0, 3) != 0);
            #1;
            check("rand_comb_p1", reg_out_1, model_read(read_reg_address_1));
            check("rand_comb_p2", reg_out_2, model_read(read_reg_address_2));
            if (c % 150 == 149) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
